// File: rtl/multicycle_ctrl_pkg.sv
// Shared types for the multi-cycle MIPS controller.
// Build option: MC_ILLEGAL_TRAP_EN adds the TRAP state.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    typedef enum logic [2:0] {
        ALU_ADD   = 3'b000,
        ALU_SUB   = 3'b001,
        ALU_RTYPE = 3'b010,
        ALU_AND   = 3'b011,
        ALU_OR    = 3'b100,
        ALU_SLT   = 3'b111
    } alu_op_t;

    typedef enum logic [1:0] {
        PC_ALU    = 2'b00,
        PC_ALUOUT = 2'b01,
        PC_JUMP   = 2'b10
    } pc_src_t;

    typedef enum logic [1:0] {
        SRCB_RT      = 2'b00,
        SRCB_FOUR    = 2'b01,
        SRCB_IMM     = 2'b10,
        SRCB_IMM_SH2 = 2'b11
    } alu_src_b_t;

    typedef enum logic [2:0] {
        CLS_NOP,
        CLS_RTYPE,
        CLS_LW,
        CLS_SW,
        CLS_ALUI,
        CLS_BRANCH,
        CLS_JUMP,
        CLS_ILLEGAL
    } instr_class_t;

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC_R,
        S_EXEC_I,
        S_MEM_ADDR,
        S_MEM_RD,
        S_MEM_WR,
        S_WB_ALU,
        S_WB_MEM,
        S_BRANCH,
        S_JUMP
`ifdef MC_ILLEGAL_TRAP_EN
        ,
        S_TRAP
`endif
    } state_t;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Shared instruction/data memory port of the multi-cycle controller.
interface mc_mem_if;

    logic mem_req;
    logic mem_we;
    logic iord;
    logic mem_ready;

    modport master (
        output mem_req,
        output mem_we,
        output iord,
        input  mem_ready
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  iord,
        output mem_ready
    );

endinterface

// File: rtl/multicycle_ctrl_opcode_decode.sv
// Combinational instruction classifier and I-type ALUOp lookup.
module mc_opcode_decode
    import mips_pkg::*;
(
    input  logic [31:0]  instr,
    output instr_class_t cls,
    output alu_op_t      imm_op
);

    logic [5:0] op;

    assign op = instr[31:26];

    always_comb begin
        cls    = CLS_ILLEGAL;
        imm_op = ALU_ADD;
        if (instr == '0) begin
            cls = CLS_NOP;
        end else begin
            case (op)
                OP_RTYPE: cls = CLS_RTYPE;
                OP_LW:    cls = CLS_LW;
                OP_SW:    cls = CLS_SW;
                OP_BEQ:   cls = CLS_BRANCH;
                OP_BNE:   cls = CLS_BRANCH;
                OP_J:     cls = CLS_JUMP;
                OP_ADDI: begin
                    cls    = CLS_ALUI;
                    imm_op = ALU_ADD;
                end
                OP_ANDI: begin
                    cls    = CLS_ALUI;
                    imm_op = ALU_AND;
                end
                OP_ORI: begin
                    cls    = CLS_ALUI;
                    imm_op = ALU_OR;
                end
                OP_SLTI: begin
                    cls    = CLS_ALUI;
                    imm_op = ALU_SLT;
                end
                default: cls = CLS_ILLEGAL;
            endcase
        end
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS sequencing FSM, control decode and retired counter.
// Build option: MC_ILLEGAL_TRAP_EN routes unknown opcodes to a sticky TRAP.
module multicycle_ctrl
    import mips_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      instr,
    mc_mem_if.master         mem,
    output logic             ir_write,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic             branch_ne,
    output logic [1:0]       pc_src,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [2:0]       alu_op,
    output logic             reg_dst,
    output logic             reg_write,
    output logic             mem_to_reg,
    output logic [CNT_W-1:0] retired
`ifdef MC_ILLEGAL_TRAP_EN
    ,
    output logic             trap
`endif
);

    state_t       state;
    state_t       nxt;
    instr_class_t cls;
    alu_op_t      imm_op;
    logic         retire;
    logic         mem_req;
    logic         mem_we;
    logic         iord;

    mc_opcode_decode u_dec (
        .instr  (instr),
        .cls    (cls),
        .imm_op (imm_op)
    );

    assign mem.mem_req = mem_req;
    assign mem.mem_we  = mem_we;
    assign mem.iord    = iord;

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= nxt;
    end

    always_ff @(posedge clk) begin
        if (rst)         retired <= '0;
        else if (retire) retired <= retired + CNT_W'(1);
    end

    always_comb begin
        nxt           = state;
        retire        = 1'b0;
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        iord          = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        branch_ne     = 1'b0;
        pc_src        = PC_ALU;
        alu_src_a     = 1'b0;
        alu_src_b     = SRCB_RT;
        alu_op        = ALU_ADD;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        mem_to_reg    = 1'b0;
`ifdef MC_ILLEGAL_TRAP_EN
        trap          = 1'b0;
`endif
        unique case (state)
            S_IDLE: nxt = S_FETCH;
            S_FETCH: begin
                mem_req   = 1'b1;
                alu_src_b = SRCB_FOUR;
                if (mem.mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    nxt      = S_DECODE;
                end
            end
            S_DECODE: begin
                // Speculative branch target lands in ALUOut
                alu_src_b = SRCB_IMM_SH2;
                unique case (cls)
                    CLS_RTYPE:  nxt = S_EXEC_R;
                    CLS_LW:     nxt = S_MEM_ADDR;
                    CLS_SW:     nxt = S_MEM_ADDR;
                    CLS_ALUI:   nxt = S_EXEC_I;
                    CLS_BRANCH: nxt = S_BRANCH;
                    CLS_JUMP:   nxt = S_JUMP;
`ifdef MC_ILLEGAL_TRAP_EN
                    CLS_ILLEGAL: nxt = S_TRAP;
`endif
                    default: begin
                        nxt    = S_FETCH;
                        retire = 1'b1;
                    end
                endcase
            end
            S_EXEC_R: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_RTYPE;
                nxt       = S_WB_ALU;
            end
            S_EXEC_I: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                alu_op    = imm_op;
                nxt       = S_WB_ALU;
            end
            S_WB_ALU: begin
                reg_write = 1'b1;
                reg_dst   = (cls == CLS_RTYPE);
                nxt       = S_FETCH;
                retire    = 1'b1;
            end
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                nxt       = (cls == CLS_SW) ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                if (mem.mem_ready) nxt = S_WB_MEM;
            end
            S_MEM_WR: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                iord    = 1'b1;
                if (mem.mem_ready) begin
                    nxt    = S_FETCH;
                    retire = 1'b1;
                end
            end
            S_WB_MEM: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                nxt        = S_FETCH;
                retire     = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = ALU_SUB;
                pc_write_cond = 1'b1;
                pc_src        = PC_ALUOUT;
                branch_ne     = instr[26];
                nxt           = S_FETCH;
                retire        = 1'b1;
            end
            S_JUMP: begin
                pc_write = 1'b1;
                pc_src   = PC_JUMP;
                nxt      = S_FETCH;
                retire   = 1'b1;
            end
`ifdef MC_ILLEGAL_TRAP_EN
            S_TRAP: trap = 1'b1;
`endif
            default: nxt = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl with a 4-bit retired counter.
module tb_multicycle_ctrl;

    localparam int CNT_W = 4;

    localparam int ST_IDLE  = 0;
    localparam int ST_FETCH = 1;
    localparam int ST_DEC   = 2;
    localparam int ST_EXR   = 3;
    localparam int ST_EXI   = 4;
    localparam int ST_MADDR = 5;
    localparam int ST_MRD   = 6;
    localparam int ST_MWR   = 7;
    localparam int ST_WBA   = 8;
    localparam int ST_WBM   = 9;
    localparam int ST_BR    = 10;
    localparam int ST_JMP   = 11;
    localparam int ST_TRAP  = 12;

    localparam logic [31:0] I_ADD  = 32'h012A4020;
    localparam logic [31:0] I_LW   = 32'h8D090004;
    localparam logic [31:0] I_SW   = 32'hAD090004;
    localparam logic [31:0] I_BNE  = 32'h15090003;
    localparam logic [31:0] I_BEQ  = 32'h11090003;
    localparam logic [31:0] I_J    = 32'h08000010;
    localparam logic [31:0] I_ADDI = 32'h21090005;
    localparam logic [31:0] I_ANDI = 32'h31090005;
    localparam logic [31:0] I_ORI  = 32'h35090005;
    localparam logic [31:0] I_SLTI = 32'h29090005;
    localparam logic [31:0] I_ILL  = 32'hFC000000;

    typedef struct packed {
        logic [17:0]      ctl;
        logic [CNT_W-1:0] ret;
        logic             trp;
        logic [7:0]       cyc;
    } exp_t;

    logic             clk;
    logic             rst;
    logic [31:0]      instr;
    logic             ir_write;
    logic             pc_write;
    logic             pc_write_cond;
    logic             branch_ne;
    logic [1:0]       pc_src;
    logic             alu_src_a;
    logic [1:0]       alu_src_b;
    logic [2:0]       alu_op;
    logic             reg_dst;
    logic             reg_write;
    logic             mem_to_reg;
    logic [CNT_W-1:0] retired;
    logic             trap_obs;

    mc_mem_if mif ();

    multicycle_ctrl #(.CNT_W(CNT_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .instr         (instr),
        .mem           (mif),
        .ir_write      (ir_write),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .branch_ne     (branch_ne),
        .pc_src        (pc_src),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_op        (alu_op),
        .reg_dst       (reg_dst),
        .reg_write     (reg_write),
        .mem_to_reg    (mem_to_reg),
        .retired       (retired)
`ifdef MC_ILLEGAL_TRAP_EN
        ,
        .trap          (trap_obs)
`endif
    );

`ifndef MC_ILLEGAL_TRAP_EN
    assign trap_obs = 1'b0;
`endif

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    int   ret_n  = 0;
    int   ncyc   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected control word per state: the hand-written output table
    function automatic logic [17:0] ctl(input int st, input logic [31:0] ins,
                                        input logic rdy);
        logic       req, we, io, irw, pcw, pcwc, bne, a, rd, rw, m2r;
        logic [1:0] ps, b;
        logic [2:0] op;
        {req, we, io, irw, pcw, pcwc, bne, a, rd, rw, m2r} = '0;
        ps = 2'b00;
        b  = 2'b00;
        op = 3'b000;
        case (st)
            ST_FETCH: begin
                req = 1'b1;
                b   = 2'b01;
                if (rdy) begin
                    irw = 1'b1;
                    pcw = 1'b1;
                end
            end
            ST_DEC: b = 2'b11;
            ST_EXR: begin
                a  = 1'b1;
                op = 3'b010;
            end
            ST_EXI: begin
                a = 1'b1;
                b = 2'b10;
                case (ins[31:26])
                    6'h0C:   op = 3'b011;
                    6'h0D:   op = 3'b100;
                    6'h0A:   op = 3'b111;
                    default: op = 3'b000;
                endcase
            end
            ST_WBA: begin
                rw = 1'b1;
                rd = (ins[31:26] == 6'h00);
            end
            ST_MADDR: begin
                a = 1'b1;
                b = 2'b10;
            end
            ST_MRD: begin
                req = 1'b1;
                io  = 1'b1;
            end
            ST_MWR: begin
                req = 1'b1;
                we  = 1'b1;
                io  = 1'b1;
            end
            ST_WBM: begin
                rw  = 1'b1;
                m2r = 1'b1;
            end
            ST_BR: begin
                a    = 1'b1;
                op   = 3'b001;
                pcwc = 1'b1;
                ps   = 2'b01;
                bne  = ins[26];
            end
            ST_JMP: begin
                pcw = 1'b1;
                ps  = 2'b10;
            end
            default: ;
        endcase
        return {req, we, io, irw, pcw, pcwc, bne, ps, a, b, op, rd, rw, m2r};
    endfunction

    task automatic cyc(input logic r, input logic [31:0] ins,
                       input logic rdy, input int st);
        exp_t e;
        @(posedge clk);
        #1;
        rst           = r;
        instr         = ins;
        mif.mem_ready = rdy;
        e.ctl = ctl(st, ins, rdy);
        e.ret = CNT_W'(ret_n);
        e.trp = (st == ST_TRAP);
        e.cyc = 8'(ncyc);
        ncyc++;
        q.push_back(e);
    endtask

    // Monitor: compares DUT outputs against queued expectations
    always @(negedge clk) begin
        exp_t        e;
        logic [17:0] act;
        if (q.size() > 0) begin
            e   = q.pop_front();
            act = {mif.mem_req, mif.mem_we, mif.iord, ir_write, pc_write,
                   pc_write_cond, branch_ne, pc_src, alu_src_a, alu_src_b,
                   alu_op, reg_dst, reg_write, mem_to_reg};
            checks++;
            if (act !== e.ctl) begin
                errors++;
                $display("FAIL ctl cyc=%0d got=%b want=%b", e.cyc, act, e.ctl);
            end
            checks++;
            if (retired !== e.ret) begin
                errors++;
                $display("FAIL retired cyc=%0d got=%0d want=%0d",
                         e.cyc, retired, e.ret);
            end
            checks++;
            if (trap_obs !== e.trp) begin
                errors++;
                $display("FAIL trap cyc=%0d got=%b want=%b",
                         e.cyc, trap_obs, e.trp);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst           = 1'b1;
        instr         = '0;
        mif.mem_ready = 1'b0;

        cyc(1, 0, 0, ST_IDLE);
        cyc(0, 0, 0, ST_IDLE);

        cyc(0, I_ADD, 1, ST_FETCH);
        cyc(0, I_ADD, 1, ST_DEC);
        cyc(0, I_ADD, 1, ST_EXR);
        cyc(0, I_ADD, 0, ST_WBA);
        ret_n = 1;

        cyc(0, I_LW, 0, ST_FETCH);
        cyc(0, I_LW, 0, ST_FETCH);
        cyc(0, I_LW, 1, ST_FETCH);
        cyc(0, I_LW, 1, ST_DEC);
        cyc(0, I_LW, 1, ST_MADDR);
        cyc(0, I_LW, 0, ST_MRD);
        cyc(0, I_LW, 0, ST_MRD);
        cyc(0, I_LW, 1, ST_MRD);
        cyc(0, I_LW, 1, ST_WBM);
        ret_n = 2;

        cyc(0, I_BNE, 1, ST_FETCH);
        cyc(0, I_BNE, 0, ST_DEC);
        cyc(0, I_BNE, 1, ST_BR);
        ret_n = 3;
        cyc(0, I_BEQ, 1, ST_FETCH);
        cyc(0, I_BEQ, 0, ST_DEC);
        cyc(0, I_BEQ, 0, ST_BR);
        ret_n = 4;

        cyc(0, I_J, 1, ST_FETCH);
        cyc(0, I_J, 0, ST_DEC);
        cyc(0, I_J, 1, ST_JMP);
        ret_n = 5;
        cyc(0, 0, 1, ST_FETCH);
        cyc(0, 0, 1, ST_DEC);
        ret_n = 6;

        cyc(0, I_ADDI, 1, ST_FETCH);
        cyc(0, I_ADDI, 1, ST_DEC);
        cyc(0, I_ADDI, 1, ST_EXI);
        cyc(0, I_ADDI, 1, ST_WBA);
        ret_n = 7;
        cyc(0, I_ANDI, 1, ST_FETCH);
        cyc(0, I_ANDI, 0, ST_DEC);
        cyc(0, I_ANDI, 0, ST_EXI);
        cyc(0, I_ANDI, 0, ST_WBA);
        ret_n = 8;
        cyc(0, I_ORI, 1, ST_FETCH);
        cyc(0, I_ORI, 1, ST_DEC);
        cyc(0, I_ORI, 1, ST_EXI);
        cyc(0, I_ORI, 1, ST_WBA);
        ret_n = 9;
        cyc(0, I_SLTI, 1, ST_FETCH);
        cyc(0, I_SLTI, 1, ST_DEC);
        cyc(0, I_SLTI, 1, ST_EXI);
        cyc(0, I_SLTI, 1, ST_WBA);
        ret_n = 10;

        cyc(0, I_SW, 1, ST_FETCH);
        cyc(0, I_SW, 1, ST_DEC);
        cyc(0, I_SW, 1, ST_MADDR);
        cyc(0, I_SW, 1, ST_MWR);
        ret_n = 11;

        cyc(0, I_SW, 1, ST_FETCH);
        cyc(0, I_SW, 1, ST_DEC);
        cyc(0, I_SW, 0, ST_MADDR);
        cyc(1, I_SW, 0, ST_MWR);
        ret_n = 0;
        cyc(0, I_SW, 1, ST_IDLE);

        for (int i = 0; i < 16; i++) begin
            cyc(0, 0, 1, ST_FETCH);
            cyc(0, 0, 0, ST_DEC);
            ret_n = (i == 15) ? 0 : i + 1;
        end

        cyc(0, I_ILL, 1, ST_FETCH);
        cyc(0, I_ILL, 1, ST_DEC);
`ifdef MC_ILLEGAL_TRAP_EN
        cyc(0, I_ILL, 1, ST_TRAP);
        cyc(0, 0, 1, ST_TRAP);
        cyc(0, I_ADD, 0, ST_TRAP);
        cyc(1, 0, 1, ST_TRAP);
`else
        ret_n = 1;
        cyc(1, 0, 1, ST_FETCH);
`endif
        ret_n = 0;
        cyc(0, 0, 0, ST_IDLE);
        cyc(0, 0, 0, ST_FETCH);

        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain left=%0d want=0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multi-cycle sequencing controller for the single-memory MIPS datapath. It steps each instruction through fetch, decode, execute, memory and write-back states, and drives the datapath muxes, enables and ALUOp from the current state. It handshakes with the shared instruction/data memory and keeps a retired-instruction counter. It replaces single-cycle opcode decoding wherever the datapath shares one memory port and one ALU across cycles.

## Interface
- `CNT_W`, default 32: width of the retired-instruction counter.
- `clk` in 1: sole clock; all state changes on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `instr` in 32: current IR contents. Opcode is `instr[31:26]`; all-zero means NOP.
- `mem_ready` in 1: memory completes the pending access in this cycle.
- `mem_req`, `mem_we` out 1 each: memory access request, and write qualifier for that request.
- `iord` out 1: memory address select. 0 = PC, 1 = ALUOut.
- `ir_write`, `pc_write`, `pc_write_cond` out 1 each: enables for IR, PC, and conditional PC.
- `branch_ne` out 1: 1 = take the branch on not-equal (BNE), 0 = on equal (BEQ).
- `pc_src` out 2: PC source. 00 = ALU, 01 = ALUOut, 10 = jump target.
- `alu_src_a` out 1: 0 = PC, 1 = rs.
- `alu_src_b` out 2: 00 = rt, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate shifted left 2.
- `alu_op` out 3: 000 add, 001 sub, 010 R-type (funct decides), 011 and, 100 or, 111 slt.
- `reg_dst`, `reg_write`, `mem_to_reg` out 1 each: register-file write controls.
- `retired` out CNT_W: count of completed instructions.
- `trap` out 1: present only with `MC_ILLEGAL_TRAP_EN` (see Configuration).

## Operation
- **States:** IDLE, FETCH, DECODE, EXEC_R, EXEC_I, MEM_ADDR, MEM_RD, MEM_WR, WB_ALU, WB_MEM, BRANCH, JUMP, TRAP.
- **Output rule:** every output not listed for a state is 0.
- **IDLE:** entered only from reset; all outputs 0; always moves to FETCH.
- **FETCH:** `mem_req`=1, `iord`=0, `alu_src_a`=0, `alu_src_b`=01, `alu_op`=000.
  - While `mem_ready`=0, hold FETCH.
  - In the cycle `mem_ready`=1, also assert `ir_write`=1 and `pc_write`=1 with `pc_src`=00, then go to DECODE.
- **DECODE:** `alu_src_a`=0, `alu_src_b`=11, `alu_op`=000 (branch target into ALUOut). Next state by instruction:
  - `instr`==0: FETCH (NOP, retired).
  - opcode 000000: EXEC_R.
  - 100011 (LW) or 101011 (SW): MEM_ADDR.
  - 001000 / 001100 / 001101 / 001010 (ADDI / ANDI / ORI / SLTI): EXEC_I.
  - 000100 (BEQ) or 000101 (BNE): BRANCH.
  - 000010 (J): JUMP.
  - any other opcode: see Configuration.
- **EXEC_R:** `alu_src_a`=1, `alu_src_b`=00, `alu_op`=010; then WB_ALU.
- **EXEC_I:** `alu_src_a`=1, `alu_src_b`=10, `alu_op` = 000 (ADDI), 011 (ANDI), 100 (ORI) or 111 (SLTI); then WB_ALU.
- **WB_ALU:** `reg_write`=1, `mem_to_reg`=0, `reg_dst` = 1 if the opcode is R-type, else 0; then FETCH.
- **MEM_ADDR:** `alu_src_a`=1, `alu_src_b`=10, `alu_op`=000; go to MEM_RD for LW, MEM_WR for SW.
- **MEM_RD:** `mem_req`=1, `iord`=1; hold until `mem_ready`=1, then go to WB_MEM.
- **MEM_WR:** `mem_req`=1, `mem_we`=1, `iord`=1; hold until `mem_ready`=1, then go to FETCH.
- **WB_MEM:** `reg_write`=1, `mem_to_reg`=1, `reg_dst`=0; then FETCH.
- **BRANCH:** `alu_src_a`=1, `alu_src_b`=00, `alu_op`=001, `pc_write_cond`=1, `pc_src`=01, `branch_ne` = opcode[0]; then FETCH.
- **JUMP:** `pc_write`=1, `pc_src`=10; then FETCH.
- **Retired counter:**
  - Increments by 1 on every transition into FETCH from DECODE, WB_ALU, WB_MEM, MEM_WR, BRANCH or JUMP.
  - Wraps from 2^CNT_W−1 to 0.

## Timing
- **Register/combinational split:** the state register and `retired` are the only sequential elements. Outputs are combinational from state and `instr`; `ir_write` and `pc_write` in FETCH additionally depend on `mem_ready`.
- **Reset:** sampled at a clock edge; the next state is IDLE and `retired` becomes 0. This applies mid-instruction too: any pending memory request is abandoned and `mem_req` falls in the cycle after the edge.
- **Latency with zero-wait memory** (`mem_ready` high in the request cycle):
  - R-type and I-type ALU: 4 cycles.
  - LW: 5 cycles.
  - SW: 4 cycles.
  - BEQ, BNE, J: 3 cycles.
  - NOP: 2 cycles.
- **Wait states:** each cycle with `mem_ready`=0 in FETCH, MEM_RD or MEM_WR adds exactly one cycle. Control outputs hold steady during the wait.
- **Stray ready:** `mem_ready` outside FETCH, MEM_RD and MEM_WR is ignored.
- **First fetch:** after reset is released, IDLE lasts 1 cycle; `mem_req` first rises in the second cycle.

## Configuration
- **`MC_ILLEGAL_TRAP_EN` defined:**
  - An unknown opcode in DECODE goes to TRAP. TRAP drives all outputs 0 and `trap`=1, is sticky until `rst`, and does not increment `retired`.
- **`MC_ILLEGAL_TRAP_EN` undefined:**
  - An unknown opcode is treated as NOP: DECODE→FETCH, counted as retired.
  - The `trap` port and the TRAP state are absent.

## Structure
- **Package `mips_pkg`:** opcode constants, ALUOp codes, the `pc_src` and `alu_src_b` encodings, and the state enum.
- **Sub-module `mc_opcode_decode`:** combinational; maps `instr` to an instruction class and the I-type ALUOp. The FSM, output decode and counter live in the top module.

## Test plan
- **R-type:** reset, then `instr`=0x012A4020 (add) with zero-wait memory → states FETCH, DECODE, EXEC_R, WB_ALU; `reg_write`=1 and `reg_dst`=1 in cycle 4; `retired`=1.
- **LW with wait states:** LW 0x8D090004, `mem_ready` low for 2 cycles in both FETCH and MEM_RD → 9 cycles total; `mem_to_reg`=1 in WB_MEM; `mem_req` held steady across the waits.
- **BNE:** BNE 0x15090003 → `pc_write_cond`=1, `branch_ne`=1, `alu_op`=001, `pc_src`=01 in cycle 3. Repeat with BEQ 0x11090003: same, but `branch_ne`=0.
- **J and NOP:** J 0x08000010 → `pc_write`=1, `pc_src`=10 in cycle 3. `instr`=0 → back to FETCH after DECODE; `retired` increments.
- **Reset mid-operation:** assert `rst` during MEM_WR with `mem_ready`=0 → next cycle state IDLE, `mem_req`=0, `retired`=0.
- **Illegal opcode and counter wrap:** opcode 0x3F with the macro defined → `trap`=1 and stays high, `retired` unchanged. With the macro undefined, retired as NOP. Separately, with CNT_W=4 → `retired` goes 15→0 on the 16th instruction.
